// File: rtl/lstm_cstate_update_pkg.sv
// rtl/lstm_cstate_update_pkg.sv - shared constants, FSM encoding and saturation helper for the cell-state stage
// saturate() is only referenced when LSTM_CSTATE_SAT_EN is defined.
package lstm_cstate_update_pkg;

  localparam int WIDTH    = 32;
  localparam int FRAC     = 24;
  localparam int NUM_LSTM = 53;
  localparam int TIMESTEP = 7;
  localparam int ADDR_W   = 9;

  localparam int N_W = (NUM_LSTM > 1) ? $clog2(NUM_LSTM) : 1;
  localparam int T_W = (TIMESTEP > 1) ? $clog2(TIMESTEP) : 1;

  typedef logic [2:0] state_t;
  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_FETCH = 3'd1;
  localparam state_t S_MUL   = 3'd2;
  localparam state_t S_WRITE = 3'd3;
  localparam state_t S_HOLD  = 3'd4;

  // A value fits in WIDTH bits when its top WIDTH+1 bits are all copies of the sign.
  function automatic logic [WIDTH-1:0] saturate(input logic [2*WIDTH-1:0] x);
    if (x[2*WIDTH-1:WIDTH-1] == {(WIDTH+1){1'b0}} ||
        x[2*WIDTH-1:WIDTH-1] == {(WIDTH+1){1'b1}})
      return x[WIDTH-1:0];
    return x[2*WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  endfunction

endpackage

// File: rtl/lstm_cstate_update_fxp_mul.sv
// rtl/lstm_cstate_update_fxp_mul.sv - signed fixed-point multiply, arithmetic shift by FRAC
// LSTM_CSTATE_SAT_EN: clamp the shifted product to WIDTH bits instead of wrapping.
module fxp_mul
  import lstm_cstate_update_pkg::*;
(
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic        [WIDTH-1:0] p
);

  logic signed [2*WIDTH-1:0] a_ext;
  logic signed [2*WIDTH-1:0] b_ext;

  assign a_ext = {{WIDTH{a[WIDTH-1]}}, a};
  assign b_ext = {{WIDTH{b[WIDTH-1]}}, b};

`ifdef LSTM_CSTATE_SAT_EN
  logic signed [2*WIDTH-1:0] shifted;
  assign shifted = (a_ext * b_ext) >>> FRAC;
  assign p       = saturate(shifted);
`else
  assign p = WIDTH'((a_ext * b_ext) >>> FRAC);
`endif

endmodule

// File: rtl/lstm_cstate_update.sv
// rtl/lstm_cstate_update.sv - LSTM cell-state update c_t = f*c_prev + i*g with memory_c read/write-back
// LSTM_CSTATE_SAT_EN: saturating products and sum; otherwise two's-complement wrap.
module lstm_cstate_update
  import lstm_cstate_update_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  f_in,
  input  logic [WIDTH-1:0]  i_in,
  input  logic [WIDTH-1:0]  g_in,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [WIDTH-1:0]  mem_rd_data,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [WIDTH-1:0]  mem_wr_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  c_out,
  output logic              seq_done
);

  state_t            state;
  logic [N_W-1:0]    n_r;
  logic [T_W-1:0]    t_r;
  logic [ADDR_W-1:0] addr_r;
  logic [WIDTH-1:0]  f_r, i_r, g_r, c_prev_r, c_r;
  logic [WIDTH-1:0]  p1, p2, c_next;
  logic              hs, last_unit, last_step;

  fxp_mul u_mul_fc (.a(f_r), .b(c_prev_r), .p(p1));
  fxp_mul u_mul_ig (.a(i_r), .b(g_r),      .p(p2));

`ifdef LSTM_CSTATE_SAT_EN
  logic [WIDTH:0] sum;
  assign sum    = {p1[WIDTH-1], p1} + {p2[WIDTH-1], p2};
  assign c_next = saturate({{(WIDTH-1){sum[WIDTH]}}, sum});
`else
  assign c_next = p1 + p2;
`endif

  // addr_r tracks t*NUM_LSTM+n linearly, so no multiplier is needed.
  assign mem_rd_addr = addr_r;
  assign mem_wr_addr = addr_r + ADDR_W'(NUM_LSTM);
  assign mem_wr_data = c_r;
  assign c_out       = c_r;
  assign mem_wr      = (state == S_WRITE);
  assign out_valid   = (state == S_WRITE) || (state == S_HOLD);
  assign in_ready    = (state == S_IDLE);
  assign hs          = out_valid && out_ready;
  assign last_unit   = (n_r == N_W'(NUM_LSTM - 1));
  assign last_step   = (t_r == T_W'(TIMESTEP - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      n_r      <= '0;
      t_r      <= '0;
      addr_r   <= '0;
      f_r      <= '0;
      i_r      <= '0;
      g_r      <= '0;
      c_prev_r <= '0;
      c_r      <= '0;
      seq_done <= 1'b0;
    end else if (clr) begin
      state    <= S_IDLE;
      n_r      <= '0;
      t_r      <= '0;
      addr_r   <= '0;
      seq_done <= 1'b0;
    end else begin
      seq_done <= hs && last_unit && last_step;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            f_r   <= f_in;
            i_r   <= i_in;
            g_r   <= g_in;
            state <= S_FETCH;
          end
        end
        S_FETCH: begin
          c_prev_r <= mem_rd_data;
          state    <= S_MUL;
        end
        S_MUL: begin
          c_r   <= c_next;
          state <= S_WRITE;
        end
        S_WRITE, S_HOLD: begin
          if (out_ready) begin
            state <= S_IDLE;
            if (last_unit) begin
              n_r <= '0;
              if (last_step) begin
                t_r    <= '0;
                addr_r <= '0;
              end else begin
                t_r    <= t_r + 1'b1;
                addr_r <= addr_r + 1'b1;
              end
            end else begin
              n_r    <= n_r + 1'b1;
              addr_r <= addr_r + 1'b1;
            end
          end else begin
            state <= S_HOLD;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lstm_cstate_update.sv
// tb/tb_lstm_cstate_update.sv - directed self-checking bench for lstm_cstate_update with a memory_c model
module tb_lstm_cstate_update;

  logic        clk = 1'b0;
  logic        rst, clr, in_valid, in_ready, out_ready, out_valid;
  logic [31:0] f_in, i_in, g_in, mem_rd_data, mem_wr_data, c_out;
  logic [8:0]  mem_rd_addr, mem_wr_addr;
  logic        mem_wr, seq_done;

  logic [31:0] mem [0:511];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          wr_cnt  = 0;
  int          seq_cnt = 0;
  logic [8:0]  last_wr = '0;

  always #5 clk = ~clk;

  lstm_cstate_update dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .f_in(f_in), .i_in(i_in), .g_in(g_in),
    .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_wr(mem_wr), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .c_out(c_out), .seq_done(seq_done)
  );

  assign mem_rd_data = mem[mem_rd_addr];

  always @(posedge clk) begin
    if (mem_wr) begin
      mem[mem_wr_addr] <= mem_wr_data;
      wr_cnt           <= wr_cnt + 1;
      last_wr          <= mem_wr_addr;
    end
  end

  always @(negedge clk) if (seq_done) seq_cnt <= seq_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_reset_values();
    check("rst_in_ready",  32'(in_ready),    32'd1);
    check("rst_out_valid", 32'(out_valid),   32'd0);
    check("rst_mem_wr",    32'(mem_wr),      32'd0);
    check("rst_seq_done",  32'(seq_done),    32'd0);
    check("rst_c_out",     c_out,            32'd0);
    check("rst_wr_addr",   32'(mem_wr_addr), 32'd53);
    check("rst_rd_addr",   32'(mem_rd_addr), 32'd0);
  endtask

  // One accept -> FETCH -> MUL -> WRITE (handshake with out_ready=1) -> IDLE pass.
  task automatic run_item(input logic [31:0] f, input logic [31:0] i, input logic [31:0] g,
                          input logic [31:0] exp_c, input int rd);
    @(negedge clk);
    in_valid = 1'b1; f_in = f; i_in = i; g_in = g;
    @(negedge clk);
    in_valid = 1'b0;
    check("fetch_rd_addr",  32'(mem_rd_addr), 32'(rd));
    check("fetch_in_ready", 32'(in_ready),    32'd0);
    @(negedge clk);
    check("mul_mem_wr",     32'(mem_wr),      32'd0);
    @(negedge clk);
    check("wr_mem_wr",      32'(mem_wr),      32'd1);
    check("wr_out_valid",   32'(out_valid),   32'd1);
    check("wr_c_out",       c_out,            exp_c);
    check("wr_data",        mem_wr_data,      exp_c);
    check("wr_addr",        32'(mem_wr_addr), 32'(rd + 53));
    @(negedge clk);
    check("post_in_ready",  32'(in_ready),    32'd1);
    check("post_out_valid", 32'(out_valid),   32'd0);
  endtask

  initial begin
    logic [31:0] held_c;
    logic [31:0] exp_sat;
    int          wr_before;

    for (int k = 0; k < 512; k++) mem[k] = '0;
    rst = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    f_in = '0; i_in = '0; g_in = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_values();

    // 0.5*2.0 + 1.0*0.25 = 1.25
    mem[0] = 32'h0200_0000;
    run_item(32'h0080_0000, 32'h0100_0000, 32'h0040_0000, 32'h0140_0000, 0);

    // 127*127 overflows: clamps or keeps the low 32 bits of 0x3F_0100_0000
`ifdef LSTM_CSTATE_SAT_EN
    exp_sat = 32'h7FFF_FFFF;
`else
    exp_sat = 32'h0100_0000;
`endif
    mem[1] = 32'h7F00_0000;
    run_item(32'h7F00_0000, 32'h0, 32'h0, exp_sat, 1);

    // 1.0*(-1.0) + 1.0*(-0.5) = -1.5
    mem[2] = 32'hFF00_0000;
    run_item(32'h0100_0000, 32'h0100_0000, 32'hFF80_0000, 32'hFE80_0000, 2);

    // Backpressure: 0.5*3.0 = 1.5 held while out_ready is low
    mem[3] = 32'h0300_0000;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; f_in = 32'h0080_0000; i_in = '0; g_in = '0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    wr_before = wr_cnt;
    held_c = 32'h0180_0000;
    check("bp_write_c_out", c_out, held_c);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_c_out",     c_out,          held_c);
      check("bp_in_ready",  32'(in_ready),  32'd0);
      check("bp_mem_wr",    32'(mem_wr),    32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", 32'(in_ready), 32'd1);
    check("bp_wr_pulses",     32'(wr_cnt - wr_before), 32'd1);
    check("bp_mem_value",     mem[56], held_c);

    // Reset asserted while the item sits in MUL
    mem[4] = 32'h0100_0000;
    @(negedge clk);
    in_valid = 1'b1; f_in = 32'h0100_0000; i_in = '0; g_in = '0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    wr_before = wr_cnt;
    rst = 1'b0;
    #1;
    check_reset_values();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    check("rstmul_no_write", 32'(wr_cnt - wr_before), 32'd0);
    run_item(32'h0080_0000, 32'h0100_0000, 32'h0040_0000, 32'h0140_0000, 0);

    // Full sequence: c grows by 1/256 per timestep, chaining through memory_c
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_rd_addr", 32'(mem_rd_addr), 32'd0);
    for (int k = 0; k < 53; k++) mem[k] = '0;
    seq_cnt = 0;
    for (int t = 0; t < 7; t++) begin
      for (int n = 0; n < 53; n++) begin
        run_item(32'h0100_0000, 32'h0100_0000, 32'h0001_0000,
                 32'((t + 1) * 32'h0001_0000), t * 53 + n);
      end
    end
    check("seq_done_pulse", 32'(seq_done), 32'd1);
    repeat (3) @(negedge clk);
    check("seq_done_count", 32'(seq_cnt),     32'd1);
    check("seq_last_wr",    32'(last_wr),     32'd423);
    check("seq_mem_423",    mem[423],         32'h0007_0000);
    check("seq_rd_wrap",    32'(mem_rd_addr), 32'd0);
    check("seq_wr_wrap",    32'(mem_wr_addr), 32'd53);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
